// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M/RV64M multiply/divide unit for the execute stage.
//            Radix-2 shift-add multiply and restoring divide on operand
//            magnitudes, with signs applied on completion. Division by zero
//            and signed overflow complete one cycle after acceptance, without
//            iterating.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start_i        operation request (sampled in IDLE only)
//   funct3_i       MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU select
//   rs1_i, rs2_i   operands (dividend/multiplicand, divisor/multiplier)
//   rd_addr_i      destination register
//   flush_i        abort the current operation
//   hold_flag_o    pipeline stall request
//   busy_o         unit not idle
//   done_o         one-cycle result-valid pulse
//   reg_wr_en_o    register write enable (same as done_o)
//   reg_wr_addr_o  latched destination register
//   reg_wr_data_o  result, zero unless done_o is high
// ============================================================================
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            hold_flag_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            reg_wr_en_o,
  output logic [4:0]      reg_wr_addr_o,
  output logic [XLEN-1:0] reg_wr_data_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(1);
  localparam logic [XLEN-1:0]  c_MIN      = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  c_ONES     = {XLEN{1'b1}};

  state_e                state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [4:0]            rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // opa: multiplicand (MUL*) or divisor (DIV*) magnitude.
  // opb: multiplier shifted right (MUL*) or dividend shifted left with
  //      quotient bits entering at the bottom (DIV*).
  logic [XLEN-1:0]       opa_q, opa_d;
  logic [XLEN-1:0]       opb_q, opb_d;
  // Multiply: full product. Divide: partial remainder in the low half.
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic                  neg_q, neg_d;      // negate product / quotient
  logic                  rneg_q, rneg_d;    // negate remainder
  logic                  fast_q, fast_d;    // result precomputed in res_q
  logic [XLEN-1:0]       res_q, res_d;

  logic                  w_accept;
  logic                  w_sgn1, w_sgn2;
  logic                  w_op1_neg, w_op2_neg;
  logic [XLEN-1:0]       w_mag1, w_mag2;
  logic                  w_div0, w_ovf, w_fast;
  logic [XLEN-1:0]       w_fast_res;
  logic [XLEN:0]         w_mul_sum;
  logic [XLEN:0]         w_div_shift, w_div_diff;
  logic                  w_div_ge;
  logic [2*XLEN-1:0]     w_prod;
  logic [XLEN-1:0]       w_quot, w_rem, w_result;

  // --------------------------------------------------------------------------
  // Operand decode at acceptance
  // --------------------------------------------------------------------------
  always_comb begin
    // MUL-group: rs1 signed except MULHU, rs2 signed for MUL/MULH only.
    // DIV-group: both signed for DIV/REM (funct3[0] = 0).
    w_sgn1 = funct3_i[2] ? ~funct3_i[0] : (funct3_i != 3'b011);
    w_sgn2 = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];

    w_op1_neg = w_sgn1 & rs1_i[XLEN-1];
    w_op2_neg = w_sgn2 & rs2_i[XLEN-1];
    w_mag1    = w_op1_neg ? -rs1_i : rs1_i;
    w_mag2    = w_op2_neg ? -rs2_i : rs2_i;

    w_div0 = funct3_i[2] & (rs2_i == '0);
    w_ovf  = funct3_i[2] & ~funct3_i[0] & (rs1_i == c_MIN) & (rs2_i == c_ONES);
    w_fast = w_div0 | w_ovf;

    // funct3[1] distinguishes REM* from DIV*.
    if (w_div0) begin
      w_fast_res = funct3_i[1] ? rs1_i : c_ONES;
    end else begin
      w_fast_res = funct3_i[1] ? '0 : rs1_i;
    end
  end

  // --------------------------------------------------------------------------
  // One iteration of each algorithm
  // --------------------------------------------------------------------------
  always_comb begin
    w_mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (opb_q[0] ? {1'b0, opa_q} : '0);
    // Remainder is always below the divisor, so the shifted value fits XLEN+1.
    w_div_shift = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
    w_div_diff  = w_div_shift - {1'b0, opa_q};
    w_div_ge    = ~w_div_diff[XLEN];
  end

  // --------------------------------------------------------------------------
  // Result formation in DONE
  // --------------------------------------------------------------------------
  always_comb begin
    w_prod = neg_q  ? -acc_q : acc_q;
    w_quot = neg_q  ? -opb_q : opb_q;
    w_rem  = rneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

    if (fast_q) begin
      w_result = res_q;
    end else begin
      unique case (funct3_q)
        3'b000:                 w_result = w_prod[XLEN-1:0];
        3'b001, 3'b010, 3'b011: w_result = w_prod[2*XLEN-1:XLEN];
        3'b100, 3'b101:         w_result = w_quot;
        default:                w_result = w_rem;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    fast_d   = fast_q;
    res_d    = res_q;

    w_accept = (state_q == S_IDLE) & start_i & ~flush_i;

    unique case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d  = w_fast ? S_DONE : S_CALC;
          funct3_d = funct3_i;
          rd_d     = rd_addr_i;
          cnt_d    = c_CNT_INIT;
          opa_d    = funct3_i[2] ? w_mag2 : w_mag1;
          opb_d    = funct3_i[2] ? w_mag1 : w_mag2;
          acc_d    = '0;
          neg_d    = w_op1_neg ^ w_op2_neg;
          rneg_d   = w_op1_neg;
          fast_d   = w_fast;
          res_d    = w_fast_res;
        end
      end

      S_CALC: begin
        cnt_d = cnt_q - c_CNT_LAST;
        if (funct3_q[2]) begin
          acc_d = {{XLEN{1'b0}}, w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0]};
          opb_d = {opb_q[XLEN-2:0], w_div_ge};
        end else begin
          acc_d = {w_mul_sum, acc_q[XLEN-1:1]};
          opb_d = {1'b0, opb_q[XLEN-1:1]};
        end

        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == c_CNT_LAST) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      fast_q   <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      fast_q   <= fast_d;
      res_q    <= res_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // rst_n gating keeps the stall low while reset is held even if start_i is.
  assign hold_flag_o   = rst_n & (w_accept | (state_q == S_CALC));
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign reg_wr_en_o   = done_o;
  assign reg_wr_addr_o = rd_q;
  assign reg_wr_data_o = done_o ? w_result : '0;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit (XLEN = 32). Expected results
//            come from a behavioural model using native 64-bit arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            hold_flag_o;
  logic            busy_o;
  logic            done_o;
  logic            reg_wr_en_o;
  logic [4:0]      reg_wr_addr_o;
  logic [XLEN-1:0] reg_wr_data_o;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .funct3_i      (funct3_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .rd_addr_i     (rd_addr_i),
    .flush_i       (flush_i),
    .hold_flag_o   (hold_flag_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .reg_wr_en_o   (reg_wr_en_o),
    .reg_wr_addr_o (reg_wr_addr_o),
    .reg_wr_data_o (reg_wr_data_o)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, sp;
    logic        [63:0] up;
    int qa, qb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    qa = a;
    qb = b;
    case (f3)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * ub; return sp[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return qa / qb;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return qa % qb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Cycles from the start cycle to the done cycle.
  function automatic int ref_latency(input logic [2:0] f3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    bit is_div, is_signed_div;
    is_div        = (f3 >= 3'd4);
    is_signed_div = (f3 == 3'd4) || (f3 == 3'd6);
    if (is_div && b == 32'd0) return 1;
    if (is_signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Driver: issue one op (start cycle = cycle 0) and wait for done_o.
  // Returns at the negedge of the done cycle. hold_ok records whether
  // hold_flag_o was high from cycle 0 up to the done cycle and low in it.
  // --------------------------------------------------------------------------
  task automatic run_op(input  logic [2:0]  f3,
                        input  logic [31:0] a,
                        input  logic [31:0] b,
                        input  logic [4:0]  rd,
                        output logic [31:0] data,
                        output int          lat,
                        output logic [4:0]  addr,
                        output logic        wr_en,
                        output bit          hold_ok);
    @(negedge clk);
    start_i   = 1'b1;
    funct3_i  = f3;
    rs1_i     = a;
    rs2_i     = b;
    rd_addr_i = rd;
    #1;
    hold_ok = (hold_flag_o === 1'b1);
    @(negedge clk);
    start_i   = 1'b0;
    funct3_i  = 3'($urandom);
    rs1_i     = $urandom;
    rs2_i     = $urandom;
    rd_addr_i = 5'($urandom);
    lat = 1;
    while (done_o !== 1'b1 && lat < 80) begin
      if (hold_flag_o !== 1'b1) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    data  = reg_wr_data_o;
    addr  = reg_wr_addr_o;
    wr_en = reg_wr_en_o;
    if (hold_flag_o !== 1'b0) hold_ok = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; rs1_i = '0; rs2_i = '0; rd_addr_i = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (hold_flag_o !== 1'b0) begin n_err++; $display("FAIL reset_hold got=%b exp=0", hold_flag_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done_o); end
    n_cmp++; if (reg_wr_en_o !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got=%b exp=0", reg_wr_en_o); end
    n_cmp++; if (reg_wr_addr_o !== 5'd0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", reg_wr_addr_o); end
    n_cmp++; if (reg_wr_data_o !== 32'd0) begin n_err++; $display("FAIL reset_data got=%h exp=0", reg_wr_data_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] data; int lat; logic [4:0] addr; logic wr; bit hok;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, data, lat, addr, wr, hok);
    n_cmp++; if (data !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_data got=%h exp=ffffffeb", data); end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_latency got=%0d exp=33", lat); end
    n_cmp++; if (hok !== 1'b1) begin n_err++; $display("FAIL mul_hold_window got=%b exp=1", hok); end
    n_cmp++; if (addr !== 5'd5) begin n_err++; $display("FAIL mul_addr got=%0d exp=5", addr); end
    n_cmp++; if (wr !== 1'b1) begin n_err++; $display("FAIL mul_wr_en got=%b exp=1", wr); end
    @(negedge clk);
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL mul_done_pulse got=%b exp=0", done_o); end
    n_cmp++; if (reg_wr_addr_o !== 5'd5) begin n_err++; $display("FAIL mul_addr_hold got=%0d exp=5", reg_wr_addr_o); end
  endtask

  task automatic test_mulh();
    logic [2:0]  f3s [3] = '{3'd1, 3'd3, 3'd2};
    logic [31:0] exps[3] = '{32'h4000_0000, 32'h4000_0000, 32'hC000_0000};
    logic [31:0] data; int lat; logic [4:0] addr; logic wr; bit hok;
    for (int i = 0; i < 3; i++) begin
      run_op(f3s[i], 32'h8000_0000, 32'h8000_0000, 5'(i + 1), data, lat, addr, wr, hok);
      n_cmp++; if (data !== exps[i]) begin n_err++; $display("FAIL mulh_f3_%0d got=%h exp=%h", f3s[i], data, exps[i]); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3s [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] exps[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd1};
    logic [31:0] data; int lat; logic [4:0] addr; logic wr; bit hok;
    for (int i = 0; i < 4; i++) begin
      run_op(f3s[i], 32'hFFFF_FFF9, 32'd2, 5'd10, data, lat, addr, wr, hok);
      n_cmp++; if (data !== exps[i]) begin n_err++; $display("FAIL div_f3_%0d got=%h exp=%h", f3s[i], data, exps[i]); end
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL div_latency_f3_%0d got=%0d exp=33", f3s[i], lat); end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  f3s [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] data; int lat; logic [4:0] addr; logic wr; bit hok;
    for (int i = 0; i < 4; i++) begin
      run_op(f3s[i], as[i], bs[i], 5'd17, data, lat, addr, wr, hok);
      n_cmp++; if (data !== exps[i]) begin n_err++; $display("FAIL fast_data_%0d got=%h exp=%h", i, data, exps[i]); end
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL fast_latency_%0d got=%0d exp=1", i, lat); end
      n_cmp++; if (addr !== 5'd17) begin n_err++; $display("FAIL fast_addr_%0d got=%0d exp=17", i, addr); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] data; int lat; logic [4:0] addr; logic wr; bit hok;
    // Flush at cycle 10 of a DIV.
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd7; rd_addr_i = 5'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_busy got=%b exp=0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL flush_done got=%b exp=0", done_o); end
    n_cmp++; if (hold_flag_o !== 1'b0) begin n_err++; $display("FAIL flush_hold got=%b exp=0", hold_flag_o); end
    // New MUL starts at cycle 12, done at cycle 45.
    run_op(3'd0, 32'd123, 32'hFFFF_FF00, 5'd8, data, lat, addr, wr, hok);
    n_cmp++; if (data !== ref_result(3'd0, 32'd123, 32'hFFFF_FF00)) begin
      n_err++; $display("FAIL flush_mul_data got=%h exp=%h", data, ref_result(3'd0, 32'd123, 32'hFFFF_FF00)); end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL flush_mul_latency got=%0d exp=33", lat); end
    // Flush beats start.
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd3;
    #1;
    n_cmp++; if (hold_flag_o !== 1'b0) begin n_err++; $display("FAIL flush_vs_start_hold got=%b exp=0", hold_flag_o); end
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_vs_start_busy got=%b exp=0", busy_o); end
    // Flush during DONE keeps the current write.
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd5; rs1_i = 32'd9; rs2_i = 32'd0; rd_addr_i = 5'd12;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b1;
    #1;
    n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL flush_in_done_pulse got=%b exp=1", done_o); end
    n_cmp++; if (reg_wr_data_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL flush_in_done_data got=%h exp=ffffffff", reg_wr_data_o); end
    @(negedge clk);
    flush_i = 1'b0;
  endtask

  task automatic test_busy_start();
    int cyc;
    logic [31:0] exp;
    exp = ref_result(3'd6, 32'hFFFF_D8F1, 32'd37);
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd6; rs1_i = 32'hFFFF_D8F1; rs2_i = 32'd37; rd_addr_i = 5'd9;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    // Cycle 5: a second request while busy.
    start_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd11; rs2_i = 32'd13; rd_addr_i = 5'd20;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 6;
    while (done_o !== 1'b1 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL busy_start_latency got=%0d exp=33", cyc); end
    n_cmp++; if (reg_wr_data_o !== exp) begin n_err++; $display("FAIL busy_start_data got=%h exp=%h", reg_wr_data_o, exp); end
    n_cmp++; if (reg_wr_addr_o !== 5'd9) begin n_err++; $display("FAIL busy_start_addr got=%0d exp=9", reg_wr_addr_o); end
    @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL busy_start_requeue got=%b exp=0", busy_o); end
  endtask

  task automatic test_async_reset();
    logic [31:0] data; int lat; logic [4:0] addr; logic wr; bit hok;
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd99; rs2_i = 32'd77; rd_addr_i = 5'd21;
    @(negedge clk);
    start_i = 1'b0;
    repeat (19) @(negedge clk);
    // Cycle 20, mid low phase: assert reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({hold_flag_o, busy_o, done_o, reg_wr_en_o} !== 4'b0000) begin
      n_err++; $display("FAIL async_reset_flags got=%b exp=0000", {hold_flag_o, busy_o, done_o, reg_wr_en_o}); end
    n_cmp++; if (reg_wr_addr_o !== 5'd0) begin n_err++; $display("FAIL async_reset_addr got=%0d exp=0", reg_wr_addr_o); end
    n_cmp++; if (reg_wr_data_o !== 32'd0) begin n_err++; $display("FAIL async_reset_data got=%h exp=0", reg_wr_data_o); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd2, data, lat, addr, wr, hok);
    n_cmp++; if (data !== ref_result(3'd1, 32'hDEAD_BEEF, 32'h1234_5678)) begin
      n_err++; $display("FAIL post_reset_data got=%h exp=%h", data, ref_result(3'd1, 32'hDEAD_BEEF, 32'h1234_5678)); end
  endtask

  // Randomised ops issued back-to-back: each start lands in the cycle after DONE.
  task automatic test_back_to_back();
    logic [31:0] data; int lat; logic [4:0] addr; logic wr; bit hok;
    logic [2:0]  f3;
    logic [31:0] a, b, exp;
    logic [4:0]  rd;
    int          exp_lat;
    for (int i = 0; i < 48; i++) begin
      f3 = 3'(i % 8);
      a  = rand_operand();
      b  = rand_operand();
      rd = 5'($urandom);
      exp     = ref_result(f3, a, b);
      exp_lat = ref_latency(f3, a, b);
      run_op(f3, a, b, rd, data, lat, addr, wr, hok);
      n_cmp++; if (data !== exp) begin n_err++;
        $display("FAIL rand_data_%0d f3=%0d a=%h b=%h got=%h exp=%h", i, f3, a, b, data, exp); end
      n_cmp++; if (lat !== exp_lat) begin n_err++;
        $display("FAIL rand_latency_%0d f3=%0d got=%0d exp=%0d", i, f3, lat, exp_lat); end
      n_cmp++; if (addr !== rd || wr !== 1'b1) begin n_err++;
        $display("FAIL rand_write_%0d got addr=%0d en=%b exp addr=%0d en=1", i, addr, wr, rd); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fast_path();
    test_flush();
    test_busy_start();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
